// File: rtl/conv3d_engine.sv
// ---------------------------------------------------------------------------
// conv3d_engine
//   Multi-channel 2-D convolution engine. A job loads a full image and all
//   filter weights over two independent valid/ready streams, then produces
//   one result per (window row, window column, filter), evaluating one kernel
//   tap (all channels in parallel) per cycle.
//
//   Optional feature macro: CONV3D_RELU_EN -- when defined, every result is
//   clamped at zero (ReLU); otherwise the raw signed accumulator is output.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse, begins a job when idle
//   pix_valid  in   pixel stream valid
//   pix_ready  out  pixel stream ready (high in LOAD until all pixels taken)
//   pix_in     in   one pixel, channel c at [c*DW +: DW]
//   wt_valid   in   weight stream valid
//   wt_ready   out  weight stream ready (high in LOAD until all taps taken)
//   wt_in      in   one kernel tap, same channel packing as pix_in
//   y_valid    out  result valid
//   y_ready    in   result ready
//   y          out  signed result, ACC_W bits
//   busy       out  high whenever not idle
//   done       out  one-cycle pulse after the last result is accepted
// ---------------------------------------------------------------------------
module conv3d_engine #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int CH     = 3,
    parameter int NF     = 2,
    parameter int STRIDE = 1,
    parameter int DW     = 8,
    parameter int ACC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    input  logic [CH*DW-1:0]        pix_in,
    input  logic                    wt_valid,
    output logic                    wt_ready,
    input  logic [CH*DW-1:0]        wt_in,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic signed [ACC_W-1:0] y,
    output logic                    busy,
    output logic                    done
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int NWT  = NF * K * K;
    localparam int OW   = (IMG_W - K) / STRIDE + 1;
    localparam int OH   = (IMG_H - K) / STRIDE + 1;
    localparam int PAI  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int WAI  = (NWT > 1) ? $clog2(NWT) : 1;
    localparam int XW   = $clog2(IMG_W + 1);
    localparam int YW   = $clog2(IMG_H + 1);
    localparam int KW   = $clog2(K + 1);
    localparam int FW   = (NF > 1) ? $clog2(NF) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CALC = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [PAI-1:0]          pix_ptr_q;
    logic [WAI-1:0]          wt_ptr_q;
    logic                    pix_ready_q;
    logic                    wt_ready_q;
    logic [KW-1:0]           kr_q;
    logic [KW-1:0]           kc_q;
    logic [XW-1:0]           wc_q;
    logic [YW-1:0]           wr_q;
    logic [FW-1:0]           f_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] y_q;
    logic                    y_valid_q;
    logic                    busy_q;
    logic                    done_q;

    logic [CH*DW-1:0]        pix_mem [NPIX];
    logic [CH*DW-1:0]        wt_mem  [NWT];

    logic [PAI-1:0]          pix_raddr_s;
    logic [WAI-1:0]          wt_raddr_s;
    logic [CH*DW-1:0]        pix_rd_s;
    logic [CH*DW-1:0]        wt_rd_s;
    logic signed [ACC_W-1:0] tap_sum_s;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] y_d;
    logic                    last_f_s;
    logic                    last_c_s;
    logic                    last_r_s;

    assign pix_ready = pix_ready_q;
    assign wt_ready  = wt_ready_q;
    assign y_valid   = y_valid_q;
    assign y         = y_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Read addresses for the current window origin plus kernel tap offset.
    assign pix_raddr_s = PAI'((32'(wr_q) + 32'(kr_q)) * 32'(IMG_W) + 32'(wc_q) + 32'(kc_q));
    assign wt_raddr_s  = WAI'(32'(f_q) * 32'(K * K) + 32'(kr_q) * 32'(K) + 32'(kc_q));
    assign pix_rd_s    = pix_mem[pix_raddr_s];
    assign wt_rd_s     = wt_mem[wt_raddr_s];

    assign last_f_s = (f_q == FW'(NF - 1));
    assign last_c_s = (wc_q == XW'((OW - 1) * STRIDE));
    assign last_r_s = (wr_q == YW'((OH - 1) * STRIDE));

    // Channel-parallel dot product for one tap; products sign-extend, sum wraps.
    always_comb begin
        tap_sum_s = {ACC_W{1'b0}};
        for (int c = 0; c < CH; c++) begin
            tap_sum_s = tap_sum_s
                      + ACC_W'($signed(pix_rd_s[c*DW +: DW]) * $signed(wt_rd_s[c*DW +: DW]));
        end
        acc_d = acc_q + tap_sum_s;
    end

    // Output transform applied to the final accumulator value.
    always_comb begin
`ifdef CONV3D_RELU_EN
        if (acc_d[ACC_W-1]) begin
            y_d = {ACC_W{1'b0}};
        end else begin
            y_d = acc_d;
        end
`else
        y_d = acc_d;
`endif
    end

    // Image and weight storage; contents survive reset since every job reloads them.
    always_ff @(posedge clk) begin
        if (pix_ready_q && pix_valid) begin
            pix_mem[pix_ptr_q] <= pix_in;
        end
        if (wt_ready_q && wt_valid) begin
            wt_mem[wt_ptr_q] <= wt_in;
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pix_ptr_q   <= '0;
            wt_ptr_q    <= '0;
            pix_ready_q <= 1'b0;
            wt_ready_q  <= 1'b0;
            kr_q        <= '0;
            kc_q        <= '0;
            wc_q        <= '0;
            wr_q        <= '0;
            f_q         <= '0;
            acc_q       <= {ACC_W{1'b0}};
            y_q         <= {ACC_W{1'b0}};
            y_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_LOAD;
                        pix_ptr_q   <= '0;
                        wt_ptr_q    <= '0;
                        pix_ready_q <= 1'b1;
                        wt_ready_q  <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // Each ready drops on its own final beat; the streams are independent.
                    if (pix_ready_q && pix_valid) begin
                        if (pix_ptr_q == PAI'(NPIX - 1)) begin
                            pix_ready_q <= 1'b0;
                        end else begin
                            pix_ptr_q <= pix_ptr_q + PAI'(1);
                        end
                    end
                    if (wt_ready_q && wt_valid) begin
                        if (wt_ptr_q == WAI'(NWT - 1)) begin
                            wt_ready_q <= 1'b0;
                        end else begin
                            wt_ptr_q <= wt_ptr_q + WAI'(1);
                        end
                    end
                    if (!pix_ready_q && !wt_ready_q) begin
                        state_q <= S_CALC;
                        acc_q   <= {ACC_W{1'b0}};
                        kr_q    <= '0;
                        kc_q    <= '0;
                        wc_q    <= '0;
                        wr_q    <= '0;
                        f_q     <= '0;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    if (kc_q == KW'(K - 1)) begin
                        kc_q <= '0;
                        if (kr_q == KW'(K - 1)) begin
                            kr_q      <= '0;
                            state_q   <= S_OUT;
                            y_q       <= y_d;
                            y_valid_q <= 1'b1;
                        end else begin
                            kr_q <= kr_q + KW'(1);
                        end
                    end else begin
                        kc_q <= kc_q + KW'(1);
                    end
                end
                S_OUT: begin
                    if (y_ready) begin
                        y_valid_q <= 1'b0;
                        acc_q     <= {ACC_W{1'b0}};
                        state_q   <= S_CALC;
                        // Filter is the fastest index, then column, then row.
                        if (!last_f_s) begin
                            f_q <= f_q + FW'(1);
                        end else begin
                            f_q <= '0;
                            if (!last_c_s) begin
                                wc_q <= wc_q + XW'(STRIDE);
                            end else begin
                                wc_q <= '0;
                                if (!last_r_s) begin
                                    wr_q <= wr_q + YW'(STRIDE);
                                end else begin
                                    wr_q    <= '0;
                                    state_q <= S_IDLE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    pix_ready_q <= 1'b0;
                    wt_ready_q  <= 1'b0;
                    y_valid_q   <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv3d_engine.sv
// ---------------------------------------------------------------------------
// tb_conv3d_engine
//   Two engine instances: A (4x4 image, K=2, CH=3, NF=2, stride 1) and
//   B (5x5 image, K=3, CH=1, NF=1, stride 2). Expected results are computed
//   by the bench and queued when a job is launched; monitors pop and compare
//   as results are accepted.
// ---------------------------------------------------------------------------
module tb_conv3d_engine;

    localparam int DW    = 8;
    localparam int ACC_W = 32;
    localparam int ACH   = 3;
    localparam int BCH   = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                    a_start, a_pix_valid, a_pix_ready, a_wt_valid, a_wt_ready;
    logic                    a_y_valid, a_y_ready, a_busy, a_done;
    logic [ACH*DW-1:0]       a_pix_in, a_wt_in;
    logic signed [ACC_W-1:0] a_y;

    logic                    b_start, b_pix_valid, b_pix_ready, b_wt_valid, b_wt_ready;
    logic                    b_y_valid, b_y_ready, b_busy, b_done;
    logic [BCH*DW-1:0]       b_pix_in, b_wt_in;
    logic signed [ACC_W-1:0] b_y;

    conv3d_engine #(.IMG_W(4), .IMG_H(4), .K(2), .CH(ACH), .NF(2), .STRIDE(1),
                    .DW(DW), .ACC_W(ACC_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start),
        .pix_valid(a_pix_valid), .pix_ready(a_pix_ready), .pix_in(a_pix_in),
        .wt_valid(a_wt_valid), .wt_ready(a_wt_ready), .wt_in(a_wt_in),
        .y_valid(a_y_valid), .y_ready(a_y_ready), .y(a_y),
        .busy(a_busy), .done(a_done)
    );

    conv3d_engine #(.IMG_W(5), .IMG_H(5), .K(3), .CH(BCH), .NF(1), .STRIDE(2),
                    .DW(DW), .ACC_W(ACC_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start),
        .pix_valid(b_pix_valid), .pix_ready(b_pix_ready), .pix_in(b_pix_in),
        .wt_valid(b_wt_valid), .wt_ready(b_wt_ready), .wt_in(b_wt_in),
        .y_valid(b_y_valid), .y_ready(b_y_ready), .y(b_y),
        .busy(b_busy), .done(b_done)
    );

    int     n_total = 0;
    int     n_pass  = 0;
    longint qa[$];
    longint qb[$];
    int     a_res = 0, a_done_cnt = 0, b_res = 0, b_done_cnt = 0;
    logic   a_prev_stall = 1'b0;
    logic signed [ACC_W-1:0] a_prev_y = '0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_total++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Result monitor for A: scoreboard pop, stall stability, done pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_prev_stall) begin
                check("a_hold_valid", longint'(a_y_valid), 1);
                check("a_hold_y", a_y, a_prev_y);
            end
            if (a_y_valid && a_y_ready) begin
                a_res <= a_res + 1;
                if (qa.size() == 0) check("a_extra_result", 1, 0);
                else                check("a_y", a_y, qa.pop_front());
            end
            if (a_done) a_done_cnt <= a_done_cnt + 1;
        end
        a_prev_stall <= rst_n && a_y_valid && !a_y_ready;
        a_prev_y     <= a_y;
    end

    // Result monitor for B.
    always @(negedge clk) begin
        if (rst_n) begin
            if (b_y_valid && b_y_ready) begin
                b_res <= b_res + 1;
                if (qb.size() == 0) check("b_extra_result", 1, 0);
                else                check("b_y", b_y, qb.pop_front());
            end
            if (b_done) b_done_cnt <= b_done_cnt + 1;
        end
    end

    // pat: 0 all ones, 1 pixels 1 / weights -1, 2 random.
    // stall: gappy inputs and y_ready low 6 of every 7 cycles.
    // poke: pulse start during CALC. abort: reset mid-CALC instead of draining.
    task automatic job_a(input int pat, input bit stall, input bit poke, input bit abort);
        int pix [16][ACH];
        int wt  [2][4][ACH];
        int n;
        int r0;
        int d0;
        int cyc;
        longint s;
        n = 0;
        for (int i = 0; i < 16; i++)
            for (int c = 0; c < ACH; c++)
                pix[i][c] = (pat == 2) ? (int'($urandom_range(0, 255)) - 128) : 1;
        for (int f = 0; f < 2; f++)
            for (int t = 0; t < 4; t++)
                for (int c = 0; c < ACH; c++)
                    wt[f][t][c] = (pat == 0) ? 1 : (pat == 1) ? -1 : (int'($urandom_range(0, 255)) - 128);
        if (!abort) begin
            for (int r = 0; r < 3; r++)
                for (int cc = 0; cc < 3; cc++)
                    for (int f = 0; f < 2; f++) begin
                        s = 0;
                        for (int kr = 0; kr < 2; kr++)
                            for (int kc = 0; kc < 2; kc++)
                                for (int c = 0; c < ACH; c++)
                                    s += pix[(r + kr) * 4 + cc + kc][c] * wt[f][kr * 2 + kc][c];
`ifdef CONV3D_RELU_EN
                        if (s < 0) s = 0;
`endif
                        qa.push_back(s);
                        n++;
                    end
        end
        r0 = a_res;
        d0 = a_done_cnt;
        a_y_ready = !stall;
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin : pix_beat
                    int t;
                    if (stall && $urandom_range(0, 2) == 0) begin
                        a_pix_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    a_pix_valid = 1'b1;
                    for (int c = 0; c < ACH; c++) a_pix_in[c*DW +: DW] = DW'(pix[i][c]);
                    t = 0;
                    do begin @(negedge clk); t++; end while (!a_pix_ready && t < 100);
                    if (!a_pix_ready) check("a_pix_timeout", 0, 1);
                    @(posedge clk); #1;
                end
                a_pix_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 8; i++) begin : wt_beat
                    int t;
                    if (stall && $urandom_range(0, 1) == 0) begin
                        a_wt_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    a_wt_valid = 1'b1;
                    for (int c = 0; c < ACH; c++) a_wt_in[c*DW +: DW] = DW'(wt[i / 4][i % 4][c]);
                    t = 0;
                    do begin @(negedge clk); t++; end while (!a_wt_ready && t < 100);
                    if (!a_wt_ready) check("a_wt_timeout", 0, 1);
                    @(posedge clk); #1;
                end
                a_wt_valid = 1'b0;
            end
        join
        if (poke) begin
            repeat (2) @(posedge clk);
            #1 a_start = 1'b1;
            @(posedge clk); #1 a_start = 1'b0;
        end
        if (abort) begin
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b0;
            @(negedge clk);
            check("abort_busy", longint'(a_busy), 0);
            check("abort_y_valid", longint'(a_y_valid), 0);
            check("abort_pix_ready", longint'(a_pix_ready), 0);
            check("abort_wt_ready", longint'(a_wt_ready), 0);
            check("abort_done", longint'(a_done), 0);
            check("abort_y", a_y, 0);
            @(posedge clk); #1 rst_n = 1'b1;
            return;
        end
        cyc = 0;
        while (a_done_cnt == d0 && cyc < 3000) begin
            @(posedge clk); #1;
            a_y_ready = stall ? (cyc % 7 == 6) : 1'b1;
            cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("a_done_pulses", a_done_cnt - d0, 1);
        check("a_result_count", a_res - r0, n);
        check("a_queue_empty", qa.size(), 0);
        check("a_busy_idle", longint'(a_busy), 0);
    endtask

    // Strided job on B: pixel = raster index, weights 1.
    task automatic job_b();
        int r0;
        int d0;
        int cyc;
        qb.push_back(54);
        qb.push_back(72);
        qb.push_back(144);
        qb.push_back(162);
        r0 = b_res;
        d0 = b_done_cnt;
        b_y_ready = 1'b1;
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        fork
            begin
                for (int i = 0; i < 25; i++) begin : b_pix_beat
                    int t;
                    b_pix_valid = 1'b1;
                    b_pix_in = DW'(i);
                    t = 0;
                    do begin @(negedge clk); t++; end while (!b_pix_ready && t < 100);
                    if (!b_pix_ready) check("b_pix_timeout", 0, 1);
                    @(posedge clk); #1;
                end
                b_pix_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 9; i++) begin : b_wt_beat
                    int t;
                    b_wt_valid = 1'b1;
                    b_wt_in = DW'(1);
                    t = 0;
                    do begin @(negedge clk); t++; end while (!b_wt_ready && t < 100);
                    if (!b_wt_ready) check("b_wt_timeout", 0, 1);
                    @(posedge clk); #1;
                end
                b_wt_valid = 1'b0;
            end
        join
        cyc = 0;
        while (b_done_cnt == d0 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("b_done_pulses", b_done_cnt - d0, 1);
        check("b_result_count", b_res - r0, 4);
        check("b_queue_empty", qb.size(), 0);
        check("b_busy_idle", longint'(b_busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_start = 1'b0; a_pix_valid = 1'b0; a_wt_valid = 1'b0; a_y_ready = 1'b0;
        a_pix_in = '0;  a_wt_in = '0;
        b_start = 1'b0; b_pix_valid = 1'b0; b_wt_valid = 1'b0; b_y_ready = 1'b0;
        b_pix_in = '0;  b_wt_in = '0;
        #12;
        check("rst_busy", longint'(a_busy), 0);
        check("rst_y_valid", longint'(a_y_valid), 0);
        check("rst_pix_ready", longint'(a_pix_ready), 0);
        check("rst_wt_ready", longint'(a_wt_ready), 0);
        check("rst_done", longint'(a_done), 0);
        check("rst_y", a_y, 0);
        check("rst_b_busy", longint'(b_busy), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        job_a(0, 1'b0, 1'b0, 1'b0);   // all ones: 18 x 12
        job_a(1, 1'b0, 1'b0, 1'b0);   // weights -1: -12 (0 with ReLU)
        job_a(2, 1'b1, 1'b1, 1'b0);   // random, output stalls, start during CALC
        job_b();                      // stride 2: 54, 72, 144, 162
        job_a(2, 1'b0, 1'b0, 1'b1);   // reset mid-CALC
        job_a(2, 1'b0, 1'b0, 1'b0);   // full job after the reset
        job_a(0, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
